// File: rtl/mmio_dfh_walker.sv
// ---------------------------------------------------------------------------
// mmio_dfh_walker
//
// MMIO read initiator for AFU validation. On start it walks the AFU's Device
// Feature Header chain from DWORD 0 using CCI-P style c0 MMIO read requests
// and c2 read responses. It captures the 128-bit AFU_ID from the first DFH,
// counts the DFHs walked, and stops with an error code on malformed chains.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse: begin a walk (honoured only in IDLE/DONE/ERR)
//   mmio_rd_valid       read request strobe, one cycle per request
//   mmio_addr           DWORD address of the request (always even, 64-bit)
//   mmio_tid            transaction ID of the request
//   rsp_valid/tid/data  read response
//   busy                walk in progress
//   done / err          sticky completion flags (clean EOL / aborted)
//   err_code            1 timeout, 2 TID mismatch, 3 unaligned offset,
//                       4 zero offset, 5 out of MMIO span, 6 runaway,
//                       7 bad DFH type; 0 while err=0
//   afu_id              {ID_H, ID_L} read after the first DFH
//   feat_count          DFHs walked including the AFU header
//   last_feat_id        feature ID of the most recent DFH
//
// Optional feature: define DFH_WALK_LOG_EN to add a feature log
// (ports log_idx / log_data) holding {dfh_dw_addr, feature_id} per DFH
// that passes the type check.
// ---------------------------------------------------------------------------
module mmio_dfh_walker #(
  parameter int MAX_FEATURES   = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MMIO_SPAN_DW   = 32768,
  parameter int LOG_DEPTH      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         mmio_rd_valid,
  output logic [15:0]  mmio_addr,
  output logic [8:0]   mmio_tid,
  input  logic         rsp_valid,
  input  logic [8:0]   rsp_tid,
  input  logic [63:0]  rsp_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [3:0]   err_code,
  output logic [127:0] afu_id,
  output logic [4:0]   feat_count,
  output logic [11:0]  last_feat_id
`ifdef DFH_WALK_LOG_EN
  ,
  input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
  output logic [27:0]                  log_data
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] ERR_TIMEOUT = 4'd1;
  localparam logic [3:0] ERR_TID     = 4'd2;
  localparam logic [3:0] ERR_ALIGN   = 4'd3;
  localparam logic [3:0] ERR_ZERO    = 4'd4;
  localparam logic [3:0] ERR_RANGE   = 4'd5;
  localparam logic [3:0] ERR_RUNAWAY = 4'd6;
  localparam logic [3:0] ERR_TYPE    = 4'd7;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK, S_DONE, S_ERR} state_e;
  typedef enum logic [1:0] {RD_DFH, RD_IDL, RD_IDH} rd_kind_e;

  state_e      state_q, state_d;
  rd_kind_e    kind_q, kind_d;
  logic [8:0]  tid_q, tid_d, tid_next_q, tid_next_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0] addr_q, addr_d, dfh_dw_q, dfh_dw_d, next_dw_q, next_dw_d;
  logic [3:0]  dfh_type_q, dfh_type_d;
  logic        dfh_eol_q, dfh_eol_d;
  logic [23:0] dfh_off_q, dfh_off_d;
  logic        rd_valid_q, rd_valid_d, busy_q, busy_d;
  logic        done_q, done_d, err_q, err_d;
  logic [3:0]  err_code_q, err_code_d;
  logic [127:0] afu_id_q, afu_id_d;
  logic [4:0]  feat_count_q, feat_count_d;
  logic [11:0] last_feat_id_q, last_feat_id_d;

  logic        start_ok_s, type_ok_s, issue_s;
  logic [15:0] issue_addr_s;
  rd_kind_e    issue_kind_s;
  logic [24:0] next_sum_s;
  logic [TMO_W-1:0] tmo_inc_s;

  assign start_ok_s = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  // The AFU header must be type 1; every later DFH must be a BBB (2) or private feature (3).
  assign type_ok_s  = (feat_count_q == 5'd1) ? (dfh_type_q == 4'd1)
                                              : ((dfh_type_q == 4'd2) || (dfh_type_q == 4'd3));
  // Byte offset is relative to the current DFH; 25 bits so a wrap past 16 bits still trips the span check.
  assign next_sum_s = {9'd0, dfh_dw_q} + {3'd0, dfh_off_q[23:2]};
  assign tmo_inc_s  = tmo_q + TMO_W'(1);

  // Next-state and output-register computation for the walk FSM.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    tid_d          = tid_q;
    tid_next_d     = tid_next_q;
    tmo_d          = tmo_q;
    addr_d         = addr_q;
    dfh_dw_d       = dfh_dw_q;
    next_dw_d      = next_dw_q;
    dfh_type_d     = dfh_type_q;
    dfh_eol_d      = dfh_eol_q;
    dfh_off_d      = dfh_off_q;
    done_d         = done_q;
    err_d          = err_q;
    err_code_d     = err_code_q;
    afu_id_d       = afu_id_q;
    feat_count_d   = feat_count_q;
    last_feat_id_d = last_feat_id_q;
    issue_s        = 1'b0;
    issue_addr_s   = 16'd0;
    issue_kind_s   = RD_DFH;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok_s) begin
          done_d       = 1'b0;
          err_d        = 1'b0;
          err_code_d   = 4'd0;
          feat_count_d = 5'd0;
          afu_id_d     = 128'd0;
          issue_s      = 1'b1;
          issue_addr_s = 16'd0;
          issue_kind_s = RD_DFH;
        end else begin
          state_d = state_q;
        end
      end
      S_REQ: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (rsp_tid != tid_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_TID;
            state_d    = S_ERR;
          end else begin
            case (kind_q)
              RD_DFH: begin
                dfh_type_d     = rsp_data[63:60];
                dfh_eol_d      = rsp_data[40];
                dfh_off_d      = rsp_data[39:16];
                last_feat_id_d = rsp_data[11:0];
                feat_count_d   = feat_count_q + 5'd1;
                state_d        = S_CHECK;
              end
              RD_IDL: begin
                afu_id_d[63:0] = rsp_data;
                issue_s        = 1'b1;
                issue_addr_s   = 16'd4;
                issue_kind_s   = RD_IDH;
              end
              RD_IDH: begin
                afu_id_d[127:64] = rsp_data;
                issue_s          = 1'b1;
                issue_addr_s     = next_dw_q;
                issue_kind_s     = RD_DFH;
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end
        end else if (tmo_inc_s == TMO_W'(TIMEOUT_CYCLES)) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end else begin
          tmo_d = tmo_inc_s;
        end
      end
      S_CHECK: begin
        if (!type_ok_s) begin
          err_d = 1'b1; err_code_d = ERR_TYPE; state_d = S_ERR;
        end else if (dfh_eol_q) begin
          done_d = 1'b1; state_d = S_DONE;
        end else if (dfh_off_q == 24'd0) begin
          err_d = 1'b1; err_code_d = ERR_ZERO; state_d = S_ERR;
        end else if (dfh_off_q[2:0] != 3'd0) begin
          err_d = 1'b1; err_code_d = ERR_ALIGN; state_d = S_ERR;
        end else if (next_sum_s >= 25'(MMIO_SPAN_DW)) begin
          err_d = 1'b1; err_code_d = ERR_RANGE; state_d = S_ERR;
        end else if (feat_count_q == 5'(MAX_FEATURES)) begin
          err_d = 1'b1; err_code_d = ERR_RUNAWAY; state_d = S_ERR;
        end else if (feat_count_q == 5'd1) begin
          // AFU header accepted: fetch AFU_ID first, remember where the chain continues.
          next_dw_d    = next_sum_s[15:0];
          issue_s      = 1'b1;
          issue_addr_s = 16'd2;
          issue_kind_s = RD_IDL;
        end else begin
          issue_s      = 1'b1;
          issue_addr_s = next_sum_s[15:0];
          issue_kind_s = RD_DFH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue_s) begin
      state_d    = S_REQ;
      addr_d     = issue_addr_s;
      kind_d     = issue_kind_s;
      tid_d      = tid_next_q;
      tid_next_d = tid_next_q + 9'd1;
      if (issue_kind_s == RD_DFH) begin
        dfh_dw_d = issue_addr_s;
      end else begin
        dfh_dw_d = dfh_dw_q;
      end
    end else begin
      tid_next_d = tid_next_q;
    end

    rd_valid_d = issue_s;
    busy_d     = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_CHECK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;       kind_q <= RD_DFH;
      tid_q <= 9'd0;           tid_next_q <= 9'd0;
      tmo_q <= {TMO_W{1'b0}};  addr_q <= 16'd0;
      dfh_dw_q <= 16'd0;       next_dw_q <= 16'd0;
      dfh_type_q <= 4'd0;      dfh_eol_q <= 1'b0;
      dfh_off_q <= 24'd0;      rd_valid_q <= 1'b0;
      busy_q <= 1'b0;          done_q <= 1'b0;
      err_q <= 1'b0;           err_code_q <= 4'd0;
      afu_id_q <= 128'd0;      feat_count_q <= 5'd0;
      last_feat_id_q <= 12'd0;
    end else begin
      state_q <= state_d;      kind_q <= kind_d;
      tid_q <= tid_d;          tid_next_q <= tid_next_d;
      tmo_q <= tmo_d;          addr_q <= addr_d;
      dfh_dw_q <= dfh_dw_d;    next_dw_q <= next_dw_d;
      dfh_type_q <= dfh_type_d; dfh_eol_q <= dfh_eol_d;
      dfh_off_q <= dfh_off_d;  rd_valid_q <= rd_valid_d;
      busy_q <= busy_d;        done_q <= done_d;
      err_q <= err_d;          err_code_q <= err_code_d;
      afu_id_q <= afu_id_d;    feat_count_q <= feat_count_d;
      last_feat_id_q <= last_feat_id_d;
    end
  end

  assign mmio_rd_valid = rd_valid_q;
  assign mmio_addr     = addr_q;
  assign mmio_tid      = tid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign afu_id        = afu_id_q;
  assign feat_count    = feat_count_q;
  assign last_feat_id  = last_feat_id_q;

`ifdef DFH_WALK_LOG_EN
  localparam int LPW = $clog2(LOG_DEPTH) + 1;
  logic [27:0]    log_q [LOG_DEPTH];
  logic [LPW-1:0] log_cnt_q;
  logic           log_wr_s;

  // Entries past LOG_DEPTH are dropped rather than wrapping.
  assign log_wr_s = (state_q == S_CHECK) && type_ok_s && (log_cnt_q < LPW'(LOG_DEPTH));

  // Feature log storage, cleared by reset and by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_cnt_q <= {LPW{1'b0}};
      for (int i = 0; i < LOG_DEPTH; i++) log_q[i] <= 28'd0;
    end else if (start_ok_s) begin
      log_cnt_q <= {LPW{1'b0}};
      for (int i = 0; i < LOG_DEPTH; i++) log_q[i] <= 28'd0;
    end else if (log_wr_s) begin
      log_q[log_cnt_q[LPW-2:0]] <= {dfh_dw_q, last_feat_id_q};
      log_cnt_q <= log_cnt_q + LPW'(1);
    end else begin
      log_cnt_q <= log_cnt_q;
    end
  end

  assign log_data = log_q[log_idx];
`endif

endmodule

// File: tb/tb_mmio_dfh_walker.sv
// Scoreboard bench for mmio_dfh_walker: directed DFH chains are loaded into a
// small MMIO memory model; expected read addresses and expected walk results
// are queued by the stimulus and popped by independent monitors.
module tb_mmio_dfh_walker;
  localparam int TMO = 256;

  logic         clk, rst_n, start;
  logic         mmio_rd_valid;
  logic [15:0]  mmio_addr;
  logic [8:0]   mmio_tid;
  logic         rsp_valid;
  logic [8:0]   rsp_tid;
  logic [63:0]  rsp_data;
  logic         busy, done, err;
  logic [3:0]   err_code;
  logic [127:0] afu_id;
  logic [4:0]   feat_count;
  logic [11:0]  last_feat_id;
`ifdef DFH_WALK_LOG_EN
  logic [3:0]   log_idx;
  logic [27:0]  log_data;
  assign log_idx = 4'd0;
`endif

  mmio_dfh_walker #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mmio_rd_valid(mmio_rd_valid), .mmio_addr(mmio_addr), .mmio_tid(mmio_tid),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .afu_id(afu_id), .feat_count(feat_count), .last_feat_id(last_feat_id)
`ifdef DFH_WALK_LOG_EN
    , .log_idx(log_idx), .log_data(log_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         done;
    logic         err;
    logic [3:0]   code;
    logic [4:0]   fc;
    logic [127:0] id;
    logic [11:0]  fid;
  } res_t;

  res_t        exp_q[$];
  int          rd_q[$];
  logic [63:0] mem [int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rsp_mode = 0;   // 0 answer, 1 silent, 2 answer with tid+1
  int          rsp_lat  = 2;
  logic [8:0]  exp_tid = 9'd0;
  logic [11:0] exp_fid = 12'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    else return 64'd0;
  endfunction

  task automatic push_res(input logic d, input logic e, input logic [3:0] c,
                          input logic [4:0] fc, input logic [127:0] id);
    res_t r;
    r.done = d; r.err = e; r.code = c; r.fc = fc; r.id = id; r.fid = exp_fid;
    exp_q.push_back(r);
  endtask

  // Memory-mapped AFU model answering each request after rsp_lat cycles.
  initial begin
    int a;
    logic [8:0] t;
    rsp_valid = 1'b0; rsp_tid = 9'd0; rsp_data = 64'd0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      if (mmio_rd_valid === 1'b1 && rsp_mode != 1) begin
        a = int'(mmio_addr);
        t = mmio_tid;
        repeat (rsp_lat) @(negedge clk);
        rsp_tid   = (rsp_mode == 2) ? t + 9'd1 : t;
        rsp_data  = mem_rd(a);
        rsp_valid = 1'b1;
      end
    end
  end

  // Read-request monitor: address order and TID sequence.
  initial begin
    forever begin
      @(negedge clk);
      if (mmio_rd_valid === 1'b1) begin
        if (rd_q.size() == 0) begin
          chk("unexpected read addr", {112'd0, mmio_addr}, 128'hFFFF_FFFF);
        end else begin
          chk("read addr", {112'd0, mmio_addr}, rd_q.pop_front());
          chk("read tid", {119'd0, mmio_tid}, {119'd0, exp_tid});
          exp_tid = exp_tid + 9'd1;
        end
      end
    end
  end

  // Completion monitor: compares the walk result when done or err rises.
  initial begin
    logic prev, fin;
    res_t r;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      fin = done | err;
      if (fin && !prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected completion", {127'd0, fin}, 128'd0);
        end else begin
          r = exp_q.pop_front();
          chk("done",         {127'd0, done},        {127'd0, r.done});
          chk("err",          {127'd0, err},         {127'd0, r.err});
          chk("err_code",     {124'd0, err_code},    {124'd0, r.code});
          chk("feat_count",   {123'd0, feat_count},  {123'd0, r.fc});
          chk("afu_id",       afu_id,                r.id);
          chk("last_feat_id", {116'd0, last_feat_id}, {116'd0, r.fid});
        end
      end
      prev = fin;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run(input string name);
    int k;
    pulse_start();
    for (k = 0; k < 3000 && !(done || err); k++) @(negedge clk);
    if (!(done || err)) chk({name, " finish within bound"}, 128'd0, 128'd1);
    @(negedge clk);
    chk({name, " reads pending"}, rd_q.size(), 128'd0);
    chk({name, " results pending"}, exp_q.size(), 128'd0);
  endtask

  task automatic check_idle(input string name);
    chk({name, " busy"},     {127'd0, busy},          128'd0);
    chk({name, " done"},     {127'd0, done},          128'd0);
    chk({name, " err"},      {127'd0, err},           128'd0);
    chk({name, " err_code"}, {124'd0, err_code},      128'd0);
    chk({name, " rd_valid"}, {127'd0, mmio_rd_valid}, 128'd0);
    chk({name, " tid"},      {119'd0, mmio_tid},      128'd0);
    chk({name, " addr"},     {112'd0, mmio_addr},     128'd0);
    chk({name, " afu_id"},   afu_id,                  128'd0);
    chk({name, " fc"},       {123'd0, feat_count},    128'd0);
    chk({name, " fid"},      {116'd0, last_feat_id},  128'd0);
  endtask

  task automatic load_afu(input logic [63:0] dfh0, input logic [63:0] idl, input logic [63:0] idh);
    mem.delete();
    mem[0] = dfh0; mem[2] = idl; mem[4] = idh;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Spec example: AFU header then EOL private feature at DW 6.
    load_afu(64'h1000_0000_0018_1001, 64'hAAAA, 64'hBBBB);
    mem[6] = 64'h3000_0100_0000_0012;
    rd_q = '{0, 2, 4, 6}; exp_fid = 12'h012;
    push_res(1'b1, 1'b0, 4'd0, 5'd2, {64'hBBBB, 64'hAAAA});
    run("walk ok");

    // First DFH is not an AFU header.
    load_afu(64'h3000_0000_0018_1005, 64'h1, 64'h2);
    rd_q = '{0}; exp_fid = 12'h005;
    push_res(1'b0, 1'b1, 4'd7, 5'd1, 128'd0);
    run("bad type");

    // Unaligned offset 0x1C on the AFU header.
    load_afu(64'h1000_0000_001C_1001, 64'h1, 64'h2);
    rd_q = '{0}; exp_fid = 12'h001;
    push_res(1'b0, 1'b1, 4'd3, 5'd1, 128'd0);
    run("unaligned");

    // Zero offset without EOL.
    load_afu(64'h1000_0000_0000_1002, 64'h1, 64'h2);
    rd_q = '{0}; exp_fid = 12'h002;
    push_res(1'b0, 1'b1, 4'd4, 5'd1, 128'd0);
    run("zero offset");

    // Type-2 second DFH with unaligned offset: IDs are read first.
    load_afu(64'h1000_0000_0018_1001, 64'h22, 64'h11);
    mem[6] = 64'h2000_0000_001C_0033;
    rd_q = '{0, 2, 4, 6}; exp_fid = 12'h033;
    push_res(1'b0, 1'b1, 4'd3, 5'd2, {64'h11, 64'h22});
    run("unaligned 2nd");

    // Next DFH would land at 6 + 0x8000 DW: beyond the MMIO span.
    load_afu(64'h1000_0000_0018_1001, 64'h3, 64'h4);
    mem[6] = 64'h3000_0002_0000_0044;
    rd_q = '{0, 2, 4, 6}; exp_fid = 12'h044;
    push_res(1'b0, 1'b1, 4'd5, 5'd2, {64'h4, 64'h3});
    run("range");

    // Silent AFU: err registers TMO clocks after the clock that samples the request,
    // i.e. TMO+1 negedges after the one where mmio_rd_valid is seen.
    rsp_mode = 1;
    rd_q = '{0};
    push_res(1'b0, 1'b1, 4'd1, 5'd0, 128'd0);
    pulse_start();
    chk("timeout req seen", {127'd0, mmio_rd_valid}, 128'd1);
    n = 0;
    while (!err && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout latency", n, TMO + 1);
    @(negedge clk);
    chk("timeout reads pending", rd_q.size(), 128'd0);
    chk("timeout results pending", exp_q.size(), 128'd0);

    // Clean retry after the timeout.
    rsp_mode = 0;
    load_afu(64'h1000_0000_0018_1001, 64'hAAAA, 64'hBBBB);
    mem[6] = 64'h3000_0100_0000_0012;
    rd_q = '{0, 2, 4, 6}; exp_fid = 12'h012;
    push_res(1'b1, 1'b0, 4'd0, 5'd2, {64'hBBBB, 64'hAAAA});
    run("retry");

    // Response carries the wrong TID.
    rsp_mode = 2;
    rd_q = '{0};
    push_res(1'b0, 1'b1, 4'd2, 5'd0, 128'd0);
    run("bad tid");
    rsp_mode = 0;

    // Runaway: AFU at 0 -> DW 8, then type-3 DFHs every 4 DW, never EOL.
    load_afu(64'h1000_0000_0020_1001, 64'h5, 64'h6);
    for (int i = 0; i < 17; i++) mem[8 + 4 * i] = 64'h3000_0000_0010_0100 + 64'(i);
    rd_q = '{0, 2, 4};
    for (int i = 0; i < 15; i++) rd_q.push_back(8 + 4 * i);
    exp_fid = 12'h10E;
    push_res(1'b0, 1'b1, 4'd6, 5'd16, {64'h6, 64'h5});
    run("runaway");

    // Reset during WAIT; the late response must be ignored.
    rsp_lat = 10;
    rd_q = '{0};
    pulse_start();
    repeat (3) @(negedge clk);
    chk("pre-reset busy", {127'd0, busy}, 128'd1);
    rst_n = 1'b0;
    exp_tid = 9'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_idle("after reset");
    chk("after reset reads pending", rd_q.size(), 128'd0);
    rsp_lat = 2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #500000;
    $display("FAIL global watchdog: got running expected finished");
    $fatal(1);
  end
endmodule
